// File: rtl/err_vec_gen.sv
// err_vec_gen: builds the n coordinates of an error vector over GF(2^m) and
// writes them, packed d elements per row, into the error-vector memory.
//
// Each coordinate is an XOR-combination of the r basis elements of the
// support space E. The r selection bits for a coordinate arrive on a
// valid/ready random stream. The basis itself is read from an external
// basis memory with a configurable read latency (DELAY_RD = 1 or 2).
//
// Ports
//   clk        clock, rising edge
//   rst_b      asynchronous active-low reset
//   start      one-cycle start pulse (honoured only in IDLE)
//   finish     one-cycle done pulse, the cycle after the last row write
//   E_din      basis memory read data
//   E_addr     basis memory address
//   E_rw       basis memory write enable (always 0, read-only use)
//   rnd_valid  random selection word available
//   rnd_ready  block accepts a random word this cycle
//   rnd_data   selection bits, bit j selects basis[j]
//   e_do       packed row write data
//   e_addr     row address
//   e_we       row write enable
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | stepping basis addresses, capturing basis after DELAY_RD
// S_GEN   | accepting random words, filling the pack register
// S_WRITE | one-cycle row write of the pack register
// S_DONE  | one-cycle finish pulse
module err_vec_gen #(
    parameter int N        = 189,
    parameter int M        = 83,
    parameter int R        = 7,
    parameter int D        = 5,
    parameter int DELAY_RD = 1,
    localparam int WIDTH   = M * D,
    localparam int DEPTH   = (N + D - 1) / D,
    localparam int RAW     = $clog2(R),
    localparam int EAW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    output logic             finish,
    input  logic [M-1:0]     E_din,
    output logic [RAW-1:0]   E_addr,
    output logic             E_rw,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [R-1:0]     rnd_data,
    output logic [WIDTH-1:0] e_do,
    output logic [EAW-1:0]   e_addr,
    output logic             e_we
);

    localparam int LW = $clog2(R + DELAY_RD + 1);
    localparam int IW = $clog2(N + 1);
    localparam int SW = $clog2(D + 1);

    localparam logic [LW-1:0] LOAD_LAST = LW'(R + DELAY_RD - 1);
    localparam logic [LW-1:0] LOAD_ADDR = LW'(R);
    localparam logic [IW-1:0] I_LAST    = IW'(N - 1);
    localparam logic [IW-1:0] I_TOTAL   = IW'(N);
    localparam logic [SW-1:0] S_LAST    = SW'(D - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GEN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      lc_q, lc_d;
    logic [IW-1:0]      i_q, i_d;
    logic [SW-1:0]      s_q, s_d;
    logic [EAW-1:0]     row_q, row_d;
    logic [WIDTH-1:0]   pack_q, pack_d;
    logic [M-1:0]       basis_q [R];
    logic [M-1:0]       basis_d [R];
    logic [M-1:0]       coord;

    assign E_rw = 1'b0;

    always_comb begin
        coord = '0;
        for (int j = 0; j < R; j++) begin
            if (rnd_data[j]) begin
                coord = coord ^ basis_q[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            lc_q    <= '0;
            i_q     <= '0;
            s_q     <= '0;
            row_q   <= '0;
            pack_q  <= '0;
            for (int k = 0; k < R; k++) begin
                basis_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            i_q     <= i_d;
            s_q     <= s_d;
            row_q   <= row_d;
            pack_q  <= pack_d;
            basis_q <= basis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lc_d      = lc_q;
        i_d       = i_q;
        s_d       = s_q;
        row_d     = row_q;
        pack_d    = pack_q;
        basis_d   = basis_q;
        finish    = 1'b0;
        rnd_ready = 1'b0;
        e_we      = 1'b0;
        e_do      = '0;
        e_addr    = '0;
        E_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    lc_d    = '0;
                    i_d     = '0;
                    s_d     = '0;
                    row_d   = '0;
                    pack_d  = '0;
                end
            end

            S_LOAD: begin
                // Address k is driven in load cycle k; its data shows up
                // DELAY_RD cycles later and is captured at the end of that cycle.
                if (lc_q < LOAD_ADDR) begin
                    E_addr = lc_q[RAW-1:0];
                end
                for (int k = 0; k < R; k++) begin
                    if (lc_q == LW'(k + DELAY_RD)) begin
                        basis_d[k] = E_din;
                    end
                end
                if (lc_q == LOAD_LAST) begin
                    state_d = S_GEN;
                end else begin
                    lc_d = lc_q + LW'(1);
                end
            end

            S_GEN: begin
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    for (int k = 0; k < D; k++) begin
                        if (s_q == SW'(k)) begin
                            pack_d[k*M +: M] = coord;
                        end
                    end
                    i_d = i_q + IW'(1);
                    s_d = s_q + SW'(1);
                    if (s_q == S_LAST || i_q == I_LAST) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                e_we   = 1'b1;
                e_addr = row_q;
                e_do   = pack_q;
                // Clearing the pack register leaves unfilled slots of a
                // partial last row at zero.
                pack_d = '0;
                s_d    = '0;
                row_d  = row_q + EAW'(1);
                state_d = (i_q < I_TOTAL) ? S_GEN : S_DONE;
            end

            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_err_vec_gen.sv
module tb_err_vec_gen;

    localparam int N     = 189;
    localparam int M     = 83;
    localparam int R     = 7;
    localparam int D     = 5;
    localparam int WIDTH = M * D;
    localparam int DEPTH = (N + D - 1) / D;
    localparam int RAW   = $clog2(R);
    localparam int EAW   = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             start1 = 1'b0, start2 = 1'b0;
    logic             rnd_valid = 1'b0;
    logic [R-1:0]     rnd_data = '0;

    logic             finish1, finish2;
    logic [M-1:0]     e_din1, e_din2, e_din2_p;
    logic [RAW-1:0]   E_addr1, E_addr2;
    logic             E_rw1, E_rw2;
    logic             rnd_ready1, rnd_ready2;
    logic [WIDTH-1:0] e_do1, e_do2;
    logic [EAW-1:0]   e_addr1, e_addr2;
    logic             e_we1, e_we2;

    int checks = 0;
    int errors = 0;

    logic [M-1:0]     basis_mem [R];
    logic [WIDTH-1:0] img [DEPTH];
    int               exp_addr_q [$];
    logic [WIDTH-1:0] exp_data_q [$];

    always #5 clk = ~clk;

    err_vec_gen #(.N(N), .M(M), .R(R), .D(D), .DELAY_RD(1)) dut (
        .clk(clk), .rst_b(rst_b), .start(start1), .finish(finish1),
        .E_din(e_din1), .E_addr(E_addr1), .E_rw(E_rw1),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready1), .rnd_data(rnd_data),
        .e_do(e_do1), .e_addr(e_addr1), .e_we(e_we1)
    );

    err_vec_gen #(.N(N), .M(M), .R(R), .D(D), .DELAY_RD(2)) dut2 (
        .clk(clk), .rst_b(rst_b), .start(start2), .finish(finish2),
        .E_din(e_din2), .E_addr(E_addr2), .E_rw(E_rw2),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready2), .rnd_data(rnd_data),
        .e_do(e_do2), .e_addr(e_addr2), .e_we(e_we2)
    );

    function automatic logic [M-1:0] rd_mem(input logic [RAW-1:0] a);
        if (int'(a) < R) return basis_mem[a];
        return '0;
    endfunction

    // Basis memory models: one and two cycles of read latency.
    always @(posedge clk) begin
        e_din1   <= rd_mem(E_addr1);
        e_din2_p <= rd_mem(E_addr2);
        e_din2   <= e_din2_p;
    end

    function automatic logic [R-1:0] pattern(input int pmode, input int idx);
        if (pmode == 0) return R'(idx % 128);
        if (pmode == 1) return '0;
        return 7'h7F;
    endfunction

    function automatic logic [M-1:0] model_coord(input logic [R-1:0] rd);
        logic [M-1:0] acc;
        acc = '0;
        for (int j = 0; j < R; j++) if (rd[j]) acc = acc ^ basis_mem[j];
        return acc;
    endfunction

    task automatic set_basis(input int mode);
        for (int j = 0; j < R; j++)
            basis_mem[j] = (mode == 0) ? (M'(1) << j) : M'(j + 1);
    endtask

    task automatic sample(input bit use2, output logic fin, output logic rdy,
                          output logic we, output logic [WIDTH-1:0] dout,
                          output logic [EAW-1:0] ad, output logic [RAW-1:0] ea);
        fin  = use2 ? finish2    : finish1;
        rdy  = use2 ? rnd_ready2 : rnd_ready1;
        we   = use2 ? e_we2      : e_we1;
        dout = use2 ? e_do2      : e_do1;
        ad   = use2 ? e_addr2    : e_addr1;
        ea   = use2 ? E_addr2    : E_addr1;
    endtask

    task automatic run_scenario(input bit use2, input int vmode, input int pmode,
                                input int restart_at, input int abort_at, input string name);
        int coord, slot, row, nwr, nfin, load_cyc, tail, ea_addr;
        bit seen_ready, prev_we, restarted, done;
        logic [WIDTH-1:0] exp_row;
        logic fin, rdy, we;
        logic [WIDTH-1:0] dout;
        logic [EAW-1:0] ad;
        logic [RAW-1:0] ea;
        int exp_ad;
        logic [WIDTH-1:0] exp_d;

        exp_addr_q.delete();
        exp_data_q.delete();
        for (int k = 0; k < DEPTH; k++) img[k] = '1;
        coord = 0; slot = 0; row = 0; nwr = 0; nfin = 0; load_cyc = 0; tail = 0;
        seen_ready = 0; prev_we = 0; restarted = 0; done = 0; exp_row = '0;

        @(negedge clk);
        rnd_valid = 1'b0;
        if (use2) start2 = 1'b1; else start1 = 1'b1;

        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            sample(use2, fin, rdy, we, dout, ad, ea);

            if (!seen_ready) begin
                if (rdy) begin
                    seen_ready = 1;
                    checks++;
                    if (load_cyc != R + (use2 ? 2 : 1)) begin
                        errors++;
                        $display("FAIL %s load length: got %0d cycles expected %0d", name, load_cyc, R + (use2 ? 2 : 1));
                    end
                end else begin
                    if (load_cyc < R) begin
                        ea_addr = int'(ea);
                        checks++;
                        if (ea_addr != load_cyc) begin
                            errors++;
                            $display("FAIL %s E_addr step %0d: got %0d expected %0d", name, load_cyc, ea_addr, load_cyc);
                        end
                    end
                    load_cyc++;
                end
            end

            if (we) begin
                nwr++;
                checks++;
                if (rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s rnd_ready during write: got %b expected 0", name, rdy);
                end
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected write: got addr %0d expected no write", name, ad);
                end else begin
                    exp_ad = exp_addr_q.pop_front();
                    exp_d  = exp_data_q.pop_front();
                    if (int'(ad) != exp_ad || dout !== exp_d) begin
                        errors++;
                        $display("FAIL %s row write: got addr %0d data %h expected addr %0d data %h", name, ad, dout, exp_ad, exp_d);
                    end
                    img[ad] = dout;
                end
            end

            if (fin) begin
                nfin++;
                checks++;
                if (!prev_we) begin
                    errors++;
                    $display("FAIL %s finish timing: got prev e_we %b expected 1", name, prev_we);
                end
            end
            prev_we = we;
            if (nfin > 0) begin
                tail++;
                done = (tail > 4);
            end

            if (abort_at >= 0 && coord == abort_at) begin
                rst_b = 1'b0;
                #1;
                sample(use2, fin, rdy, we, dout, ad, ea);
                checks++;
                if (fin !== 1'b0 || rdy !== 1'b0 || we !== 1'b0 || dout !== '0 || ad !== '0 || ea !== '0) begin
                    errors++;
                    $display("FAIL %s async reset outputs: got fin %b rdy %b we %b addr %0d E_addr %0d expected all 0", name, fin, rdy, we, ad, ea);
                end
                rnd_valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if ((use2 ? e_we2 : e_we1) !== 1'b0) begin
                        errors++;
                        $display("FAIL %s write during reset: got e_we 1 expected 0", name);
                    end
                end
                rst_b = 1'b1;
                return;
            end

            rnd_valid = (vmode == 0) ? 1'b1 : ((cyc % 3) == 0);
            rnd_data  = pattern(pmode, coord);
            if (restart_at >= 0 && !restarted && coord == restart_at && rdy) begin
                if (use2) start2 = 1'b1; else start1 = 1'b1;
                restarted = 1;
            end
            if (rnd_valid && rdy && coord < N) begin
                exp_row[slot*M +: M] = model_coord(rnd_data);
                coord++;
                if (slot == D - 1 || coord == N) begin
                    exp_addr_q.push_back(row);
                    exp_data_q.push_back(exp_row);
                    exp_row = '0;
                    slot = 0;
                    row++;
                end else begin
                    slot++;
                end
            end
        end
        rnd_valid = 1'b0;

        checks++;
        if (nwr != DEPTH) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, nwr, DEPTH);
        end
        checks++;
        if (nfin != 1) begin
            errors++;
            $display("FAIL %s finish count: got %0d expected 1", name, nfin);
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s rows never written: got %0d left expected 0", name, exp_addr_q.size());
        end
    endtask

    // Image checks against literal expected rows (independent of the model).
    task automatic check_row(input string name, input int r_idx, input logic [WIDTH-1:0] exp);
        checks++;
        if (img[r_idx] !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, r_idx, img[r_idx], exp);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #1;
        checks++;
        if (finish1 !== 1'b0 || rnd_ready1 !== 1'b0 || e_we1 !== 1'b0 || e_do1 !== '0 ||
            e_addr1 !== '0 || E_addr1 !== '0 || E_rw1 !== 1'b0) begin
            errors++;
            $display("FAIL reset dut1 outputs: got fin %b rdy %b we %b expected all 0", finish1, rnd_ready1, e_we1);
        end
        checks++;
        if (finish2 !== 1'b0 || rnd_ready2 !== 1'b0 || e_we2 !== 1'b0 || e_do2 !== '0 ||
            e_addr2 !== '0 || E_addr2 !== '0 || E_rw2 !== 1'b0) begin
            errors++;
            $display("FAIL reset dut2 outputs: got fin %b rdy %b we %b expected all 0", finish2, rnd_ready2, e_we2);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_default_image(input string name);
        logic [WIDTH-1:0] r0, r37;
        r0 = '0;
        r37 = '0;
        for (int k = 0; k < D; k++) r0[k*M +: M] = M'(k);
        for (int k = 0; k < 4; k++) r37[k*M +: M] = M'(57 + k);
        check_row(name, 0, r0);
        check_row(name, DEPTH - 1, r37);
    endtask

    task automatic test_basic();
        set_basis(0);
        run_scenario(0, 0, 0, -1, -1, "basic");
        check_default_image("basic");
    endtask

    task automatic test_stall();
        set_basis(0);
        run_scenario(0, 1, 0, -1, -1, "stall");
        check_default_image("stall");
    endtask

    task automatic test_patterns();
        logic [WIDTH-1:0] r;
        set_basis(0);
        run_scenario(0, 0, 1, -1, -1, "zero");
        check_row("zero", 17, '0);
        set_basis(1);
        run_scenario(0, 0, 2, -1, -1, "ones_lin");
        check_row("ones_lin", 5, '0);
        set_basis(0);
        run_scenario(0, 0, 2, -1, -1, "ones_unit");
        r = '0;
        for (int k = 0; k < 4; k++) r[k*M +: M] = M'(8'h7F);
        check_row("ones_unit", DEPTH - 1, r);
    endtask

    task automatic test_restart();
        set_basis(0);
        run_scenario(0, 0, 0, 20, -1, "restart");
        check_default_image("restart");
    endtask

    task automatic test_reset_abort();
        set_basis(0);
        run_scenario(0, 0, 0, -1, 50, "abort");
        run_scenario(0, 0, 0, -1, -1, "after_abort");
        check_default_image("after_abort");
    endtask

    task automatic test_delay2();
        set_basis(0);
        run_scenario(1, 0, 0, -1, -1, "delay2");
        check_default_image("delay2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_patterns();
        test_restart();
        test_reset_abort();
        test_delay2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/err_vec_gen.md
Name: err_vec_gen

Overview:
- Encryption-side writer for the packed GF(2^m) vector memories that the decryption datapath reads (d elements per row, row width m*d).
- Loads the r basis elements of support space E from a basis memory.
- Builds each of the n error-vector coordinates as an XOR-combination of those basis elements, selected by r random bits per coordinate.
- Packs the coordinates d per row and writes them to the error-vector memory consumed by the polynomial multiplier.

Parameters:
n, 189, number of coordinates (polynomial degree)
m, 83, GF(2^m) element width
r, 7, dimension of E (basis element count)
d, 5, GF(2^m) elements per memory row
DELAY_rd, 1, basis memory read latency in cycles (1 or 2)
WIDTH, m*d, row width (derived)
DEPTH, ceil(n/d), row count (derived; 38 at defaults)

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
start  input  1  one-cycle start pulse
finish  output  1  one-cycle done pulse
E_din  input  m  basis memory read data
E_addr  output  CLOG2(r)  basis memory address
E_rw  output  1  basis memory write enable, tied 0
rnd_valid  input  1  random word available
rnd_ready  output  1  block accepts random word this cycle
rnd_data  input  r  random selection bits, bit j selects basis[j]
e_do  output  WIDTH  packed row write data
e_addr  output  CLOG2(DEPTH)  row address
e_we  output  1  row write enable

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_b.
- Outputs after reset: finish, rnd_ready, e_we = 0; e_do, e_addr, E_addr = 0. The FSM enters IDLE and the basis registers and pack register are cleared.
- States: IDLE, LOAD, GEN, WRITE, DONE.
- IDLE:
  - On start=1, go to LOAD and clear the coordinate counter i, slot counter s and row counter.
  - start in any other state is ignored.
- LOAD:
  - E_addr steps 0..r-1 on consecutive cycles.
  - E_din is captured into basis[k] exactly DELAY_rd cycles after address k is presented.
  - Go to GEN the cycle after basis[r-1] is captured. LOAD lasts r+DELAY_rd cycles.
- GEN:
  - rnd_ready=1.
  - On rnd_valid&&rnd_ready, the coordinate value is the XOR over j of (rnd_data[j] ? basis[j] : 0). It is registered into pack bits [m*s +: m]. Then i and s increment.
  - If s==d-1 or i==n-1 at acceptance, go to WRITE. Otherwise stay in GEN.
  - rnd_valid=0 stalls the block with no state change.
- WRITE:
  - rnd_ready=0. For exactly one cycle: e_we=1, e_addr=row counter, e_do=pack register.
  - Slots not filled in a partial last row are 0. At defaults row 37 holds coordinates 185..188 in slots 0..3, and slot 4 is zero.
  - Next cycle: clear the pack register, set s=0, increment the row counter.
  - Go to GEN if i<n, otherwise go to DONE.
- DONE: finish=1 for one cycle, then go to IDLE.
- Throughput and totals:
  - d coordinates per d+1 cycles with rnd_valid held high.
  - Exactly DEPTH writes per run, with addresses strictly 0..DEPTH-1 in order.
- Reset mid-operation: aborts immediately with no further writes. A subsequent start performs a complete fresh run.
- Basis values are not checked for rank; duplicates are allowed.

Test Plan:
- Defaults, basis[j]=1<<j, rnd_data=i mod 128 for coordinate i, rnd_valid always 1 -> 38 writes. Row 0 = {slot4..0}={4,3,2,1,0}; row 37 slots 0..3 = 57,58,59,60, slot 4 = 0. finish pulses once, 1 cycle after the last e_we.
- Same stimulus, rnd_valid high only every 3rd cycle -> identical memory image. e_we never asserts in a cycle without a preceding completed row; rnd_ready=0 during every WRITE cycle.
- rnd_data=0 for all coordinates -> all 38 rows zero. rnd_data=7'h7F with basis[j]=j+1 -> every coordinate = 1^2^3^4^5^6^7 = 0x0; with basis[j]=1<<j -> every coordinate = 0x7F.
- start re-pulsed at coordinate 20 during GEN -> ignored; output identical to the first scenario, single finish.
- rst_b low at coordinate 50 -> all outputs 0 asynchronously, no write after reset. The next start yields the full correct 38-row image.
- DELAY_rd=2 -> E_addr sequence 0..6, GEN entered 9 cycles after start, memory image identical to the first scenario.
